// File: rtl/cond_pkg.sv
// cond_pkg: shared types and constants for the conditional-execution unit.
//   cond_e  : the 16 ARM condition codes (Instr[31:28])
//   state_e : sequencing state for register-shifted-register instructions
//   N/Z/C/V : bit positions of the flags inside the 4-bit {N,Z,C,V} vector
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef enum logic {
    EXEC    = 1'b0,
    RS_READ = 1'b1
  } state_e;

  localparam int unsigned N = 3;
  localparam int unsigned Z = 2;
  localparam int unsigned C = 1;
  localparam int unsigned V = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: purely combinational condition evaluator.
// Ports:
//   Cond   in  cond_e  condition field of the current instruction
//   Flags  in  4       registered {N,Z,C,V}
//   CondEx out 1       1 when the instruction is allowed to execute
module cond_check
  import cond_pkg::*;
(
  input  cond_e      Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[N];
  assign z = Flags[Z];
  assign c = Flags[C];
  assign v = Flags[V];

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      EQ:      CondEx = z;
      NE:      CondEx = !z;
      CS:      CondEx = c;
      CC:      CondEx = !c;
      MI:      CondEx = n;
      PL:      CondEx = !n;
      VS:      CondEx = v;
      VC:      CondEx = !v;
      HI:      CondEx = c && !z;
      LS:      CondEx = !c || z;
      GE:      CondEx = (n == v);
      LT:      CondEx = (n != v);
      GT:      CondEx = !z && (n == v);
      LE:      CondEx = z || (n != v);
      AL:      CondEx = 1'b1;
      // 1111 is unsupported in this core and behaves as "never"
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition gating of decoder strobes, and
// two-cycle sequencing of register-shifted-register data-processing ops
// (the register file has only two read ports, so Rs is read first).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   EXEC    | normal execute; a passing reg-shifted op stalls here once
//   RS_READ | second cycle of a reg-shifted op, executes with latched Rs
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   Cond[3:0]                  condition field
//   ALUFlags[3:0]              {N,Z,C,V} from the ALU
//   ShiftCarry                 barrel shifter carry-out
//   FlagW[1:0]                 [1]=write NZ, [0]=write CV
//   ShiftOp[2:0]               0 = no shift
//   PCS, RegW, MemW            decoder strobes
//   Src2Val                    register-specified shift amount
//   PCSrc, RegWrite, MemWrite  gated strobes
//   Flags[3:0]                 registered {N,Z,C,V}
//   CondEx                     condition passed
//   Stall                      hold PC/instruction this cycle
//   RsPhase                    Rs routed to read port 2
module cond_unit
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       ShiftCarry,
  input  logic [1:0] FlagW,
  input  logic [2:0] ShiftOp,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       Src2Val,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       Stall,
  output logic       RsPhase
);

  state_e     state, state_nx;
  logic [3:0] flags_nx;
  logic       exec;
  logic       shifted;

  assign shifted = (ShiftOp != 3'b000);

  // Flags are never affected by the current ALU result, so CondEx stays
  // stable across both cycles of a register-shifted instruction.
  cond_check u_cond_check (
    .Cond   (cond_e'(Cond)),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EXEC;
      Flags <= 4'b0000;
    end else begin
      state <= state_nx;
      Flags <= flags_nx;
    end
  end

  always_comb begin
    state_nx = state;
    exec     = 1'b0;
    Stall    = 1'b0;
    RsPhase  = 1'b0;
    // Reset suppresses all side effects in the same cycle, including the
    // second half of an in-flight reg-shifted instruction.
    if (!reset) begin
      case (state)
        EXEC: begin
          if (CondEx && Src2Val && shifted) begin
            Stall    = 1'b1;
            RsPhase  = 1'b1;
            state_nx = RS_READ;
          end else begin
            exec = 1'b1;
          end
        end
        RS_READ: begin
          exec     = 1'b1;
          state_nx = EXEC;
        end
        default: state_nx = EXEC;
      endcase
    end
  end

  assign PCSrc    = exec && CondEx && PCS;
  assign RegWrite = exec && CondEx && RegW;
  assign MemWrite = exec && CondEx && MemW;

  always_comb begin
    flags_nx = Flags;
    if (exec && CondEx) begin
      if (FlagW[1]) begin
        flags_nx[N] = ALUFlags[N];
        flags_nx[Z] = ALUFlags[Z];
      end
      // An ALU carry write takes priority over the shifter carry.
      if (FlagW[0]) begin
        flags_nx[C] = ALUFlags[C];
        flags_nx[V] = ALUFlags[V];
      end else if (FlagW[1] && shifted) begin
        flags_nx[C] = ShiftCarry;
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: self-checking bench for cond_unit. Directed vector table,
// hand sequences for two-cycle and reset corner cases, then randomized
// traffic against a behavioural reference model.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic       ShiftCarry;
  logic [1:0] FlagW;
  logic [2:0] ShiftOp;
  logic       PCS, RegW, MemW, Src2Val;
  logic       PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;
  logic       CondEx, Stall, RsPhase;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  cond_unit dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
    .ShiftCarry(ShiftCarry), .FlagW(FlagW), .ShiftOp(ShiftOp),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .Src2Val(Src2Val),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondEx(CondEx), .Stall(Stall), .RsPhase(RsPhase)
  );

  typedef struct {
    string      name;
    logic [3:0] pre;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic [2:0] sop;
    logic       sc, pcs, regw, memw;
    logic [3:0] ex_out;   // {CondEx, PCSrc, RegWrite, MemWrite}
    logic [3:0] ex_flags;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                       input logic [2:0] sop, input logic sc, input logic pcs,
                       input logic regw, input logic memw, input logic src2);
    Cond = c; ALUFlags = alu; FlagW = fw; ShiftOp = sop; ShiftCarry = sc;
    PCS = pcs; RegW = regw; MemW = memw; Src2Val = src2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(4'hE, f, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("set_flags", {4'h0, Flags}, {4'h0, f});
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] pre, input logic [3:0] c,
                              input logic [3:0] alu, input logic [1:0] fw, input logic [2:0] sop,
                              input logic sc, input logic pcs, input logic regw, input logic memw,
                              input logic [3:0] ex_out, input logic [3:0] ex_flags);
    vec_t v;
    v.name = nm; v.pre = pre; v.cond = c; v.alu = alu; v.fw = fw; v.sop = sop;
    v.sc = sc; v.pcs = pcs; v.regw = regw; v.memw = memw;
    v.ex_out = ex_out; v.ex_flags = ex_flags;
    return v;
  endfunction

  // Reference condition: ARM pairs codes, odd code = inverse of even code.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  initial begin
    logic [3:0] mflags;
    bit         m_in_rs;
    logic [3:0] r_cond, r_alu;
    logic [1:0] r_fw;
    logic [2:0] r_sop;
    logic       r_sc, r_pcs, r_regw, r_memw, r_src2;

    // name, pre, cond, alu, fw, sop, sc, pcs, regw, memw, {cx,pc,rw,mw}, flags
    vecs.push_back(mk("al_regw",   4'b0000, 4'hE, 4'b1111, 2'b00, 3'd0, 0, 0, 1, 0, 4'b1010, 4'b0000));
    vecs.push_back(mk("eq_taken",  4'b0100, 4'h0, 4'b0000, 2'b00, 3'd0, 0, 1, 0, 0, 4'b1100, 4'b0100));
    vecs.push_back(mk("ne_skip",   4'b0100, 4'h1, 4'b0000, 2'b00, 3'd0, 0, 1, 0, 0, 4'b0000, 4'b0100));
    vecs.push_back(mk("hi_pass",   4'b0010, 4'h8, 4'b0000, 2'b00, 3'd0, 0, 0, 1, 0, 4'b1010, 4'b0010));
    vecs.push_back(mk("hi_fail",   4'b0110, 4'h8, 4'b0000, 2'b00, 3'd0, 0, 0, 1, 0, 4'b0000, 4'b0110));
    vecs.push_back(mk("ls_pass",   4'b0110, 4'h9, 4'b0000, 2'b00, 3'd0, 0, 0, 1, 0, 4'b1010, 4'b0110));
    vecs.push_back(mk("ge_fail",   4'b1000, 4'hA, 4'b0000, 2'b00, 3'd0, 0, 0, 0, 1, 4'b0000, 4'b1000));
    vecs.push_back(mk("lt_mem",    4'b1000, 4'hB, 4'b0000, 2'b00, 3'd0, 0, 0, 0, 1, 4'b1001, 4'b1000));
    vecs.push_back(mk("gt_pass",   4'b1001, 4'hC, 4'b0000, 2'b00, 3'd0, 0, 1, 0, 0, 4'b1100, 4'b1001));
    vecs.push_back(mk("le_fail",   4'b1001, 4'hD, 4'b0000, 2'b00, 3'd0, 0, 1, 0, 0, 4'b0000, 4'b1001));
    vecs.push_back(mk("nv_never",  4'b0000, 4'hF, 4'b1111, 2'b11, 3'd0, 0, 1, 1, 1, 4'b0000, 4'b0000));
    vecs.push_back(mk("vs_pass",   4'b0011, 4'h6, 4'b0000, 2'b00, 3'd0, 0, 0, 1, 0, 4'b1010, 4'b0011));
    vecs.push_back(mk("cc_fail",   4'b0011, 4'h3, 4'b0000, 2'b00, 3'd0, 0, 0, 1, 0, 4'b0000, 4'b0011));
    vecs.push_back(mk("ands_shc",  4'b0001, 4'hE, 4'b1010, 2'b10, 3'd1, 1, 0, 1, 0, 4'b1010, 4'b1011));
    vecs.push_back(mk("alu_c_win", 4'b0000, 4'hE, 4'b0000, 2'b11, 3'd1, 1, 0, 0, 0, 4'b1000, 4'b0000));
    vecs.push_back(mk("cv_only",   4'b0001, 4'hE, 4'b1110, 2'b01, 3'd0, 0, 0, 0, 0, 4'b1000, 4'b0010));
    vecs.push_back(mk("eq_no_fw",  4'b0000, 4'h0, 4'b1111, 2'b11, 3'd0, 0, 0, 1, 0, 4'b0000, 4'b0000));
    vecs.push_back(mk("subs_z",    4'b0000, 4'hE, 4'b0100, 2'b11, 3'd0, 0, 0, 1, 0, 4'b1010, 4'b0100));

    // Reset: strobes suppressed during reset, flags cleared afterwards
    reset = 1'b1;
    drive(4'hE, 4'b1111, 2'b11, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("reset_strobes", {2'b0, CondEx, PCSrc, RegWrite, MemWrite, Stall, RsPhase}, 8'b00100000);
    tick();
    tick();
    chk("reset_flags", {4'h0, Flags}, 8'h00);
    reset = 1'b0;
    drive(4'h0, 4'b0000, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("reset_eq_condex", {7'b0, CondEx}, 8'h00);

    foreach (vecs[i]) begin
      set_flags(vecs[i].pre);
      drive(vecs[i].cond, vecs[i].alu, vecs[i].fw, vecs[i].sop, vecs[i].sc,
            vecs[i].pcs, vecs[i].regw, vecs[i].memw, 1'b0);
      #1;
      chk({vecs[i].name, "_out"}, {2'b0, CondEx, PCSrc, RegWrite, MemWrite, Stall, RsPhase},
          {2'b0, vecs[i].ex_out, 2'b00});
      tick();
      chk({vecs[i].name, "_flags"}, {4'h0, Flags}, {4'h0, vecs[i].ex_flags});
    end

    // Register-shifted instruction: two cycles, flags written at the second
    set_flags(4'b0000);
    drive(4'hE, 4'b1000, 2'b11, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("rs_c1", {3'b0, Stall, RsPhase, RegWrite, 2'b0}, {3'b0, 1'b1, 1'b1, 1'b0, 2'b0});
    tick();
    chk("rs_c1_flags", {4'h0, Flags}, 8'h00);
    chk("rs_c2", {3'b0, Stall, RsPhase, RegWrite, 2'b0}, {3'b0, 1'b0, 1'b0, 1'b1, 2'b0});
    tick();
    chk("rs_c2_flags", {4'h0, Flags}, 8'h08);
    drive(4'hE, 4'b0000, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rs_back_exec", {3'b0, Stall, RsPhase, RegWrite, 2'b0}, {3'b0, 1'b0, 1'b0, 1'b1, 2'b0});
    tick();

    // Register-shifted but condition fails: single cycle no-op
    set_flags(4'b0000);
    drive(4'h0, 4'b1111, 2'b11, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("rs_skip", {3'b0, Stall, RsPhase, RegWrite, CondEx, 1'b0}, 8'h00);
    tick();
    chk("rs_skip_flags", {4'h0, Flags}, 8'h00);
    #1;
    chk("rs_skip_still", {3'b0, Stall, RsPhase, RegWrite, 2'b0}, 8'h00);
    tick();

    // Reset while in RS_READ
    set_flags(4'b0010);
    drive(4'hE, 4'b1111, 2'b11, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rsr_enter", {3'b0, Stall, RsPhase, 3'b0}, {3'b0, 1'b1, 1'b1, 3'b0});
    tick();
    reset = 1'b1;
    #1;
    chk("rsr_reset_out", {2'b0, PCSrc, RegWrite, MemWrite, Stall, RsPhase, 1'b0}, 8'h00);
    tick();
    reset = 1'b0;
    chk("rsr_flags", {4'h0, Flags}, 8'h00);
    #1;
    chk("rsr_exec_again", {3'b0, Stall, RsPhase, RegWrite, 2'b0}, {3'b0, 1'b1, 1'b1, 1'b0, 2'b0});
    tick();
    tick();

    // Randomized traffic against the reference model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mflags  = 4'b0000;
    m_in_rs = 1'b0;
    r_cond = 4'hE; r_alu = 4'h0; r_fw = 2'b00; r_sop = 3'd0;
    r_sc = 1'b0; r_pcs = 1'b0; r_regw = 1'b0; r_memw = 1'b0; r_src2 = 1'b0;
    for (int k = 0; k < 400; k++) begin
      logic rst_now, cx, stall_e, ex;
      // a stalled instruction is held by the pipeline
      if (!m_in_rs) begin
        r_cond = 4'($urandom_range(0, 15));
        r_alu  = 4'($urandom_range(0, 15));
        r_fw   = 2'($urandom_range(0, 3));
        r_sop  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        r_sc   = 1'($urandom_range(0, 1));
        r_pcs  = 1'($urandom_range(0, 1));
        r_regw = 1'($urandom_range(0, 1));
        r_memw = 1'($urandom_range(0, 1));
        r_src2 = 1'($urandom_range(0, 1));
      end
      rst_now = ($urandom_range(0, 31) == 0);
      reset = rst_now;
      drive(r_cond, r_alu, r_fw, r_sop, r_sc, r_pcs, r_regw, r_memw, r_src2);

      cx      = ref_cond(r_cond, mflags);
      stall_e = !rst_now && !m_in_rs && cx && r_src2 && (r_sop != 3'd0);
      ex      = !rst_now && !stall_e && cx;
      #1;
      chk("rand_out", {2'b0, CondEx, PCSrc, RegWrite, MemWrite, Stall, RsPhase},
          {2'b0, cx, ex & r_pcs, ex & r_regw, ex & r_memw, stall_e, stall_e});

      if (rst_now) begin
        mflags  = 4'b0000;
        m_in_rs = 1'b0;
      end else begin
        if (ex) begin
          if (r_fw[1]) mflags[3:2] = r_alu[3:2];
          if (r_fw[0]) mflags[1:0] = r_alu[1:0];
          else if (r_fw[1] && r_sop != 3'd0) mflags[1] = r_sc;
        end
        m_in_rs = stall_e;
      end
      tick();
      chk("rand_flags", {4'h0, Flags}, {4'h0, mflags});
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
